// File: rtl/csr_exec.sv
// ---------------------------------------------------------------------------
// csr_exec
//
// Sequencer for Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms).
// It accepts one decoded CSR request per handshake and reads the old CSR value
// through the regfile's combinational read port. It then drives one cycle of
// write pulses to the CSR write port and the rd write port, or flags the
// access as illegal and writes nothing.
//
// Timing: handshake at edge T, READ in cycle T+1, WRITE/done in cycle T+2,
// ready again in cycle T+3.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i       request valid (held by requester until accepted)
//   req_ready_o       high only in IDLE while not in reset
//   req_op_i          01=RW, 10=RS, 11=RC, 00=illegal
//   req_imm_i         1: source is zimm, 0: source is rs1 data
//   req_csr_addr_i    target CSR address
//   req_rs1_i         rs1 index (source-zero check)
//   req_rs1_data_i    rs1 value
//   req_zimm_i        5-bit immediate, zero-extended
//   req_rd_i          destination GPR index
//   csr_raddr_o       CSR read address
//   csr_rdata_i       CSR read data, combinational from csr_raddr_o
//   csr_waddr_o       CSR write address, NOP_CSR_ADDR when no write
//   csr_wdata_o       CSR write data
//   rd_waddr_o        GPR write index, 0 = no write
//   rd_wdata_o        GPR write data (old CSR value)
//   done_o            one-cycle completion pulse
//   illegal_o         one-cycle illegal flag, coincident with done_o
// ---------------------------------------------------------------------------
module csr_exec #(
    parameter int                DATA_W       = 32,
    parameter int                CSR_AW       = 12,
    parameter int                REG_AW       = 5,
    parameter logic [CSR_AW-1:0] NOP_CSR_ADDR = 12'hFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic              req_imm_i,
    input  logic [CSR_AW-1:0] req_csr_addr_i,
    input  logic [REG_AW-1:0] req_rs1_i,
    input  logic [DATA_W-1:0] req_rs1_data_i,
    input  logic [4:0]        req_zimm_i,
    input  logic [REG_AW-1:0] req_rd_i,
    output logic [CSR_AW-1:0] csr_raddr_o,
    input  logic [DATA_W-1:0] csr_rdata_i,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic [REG_AW-1:0] rd_waddr_o,
    output logic [DATA_W-1:0] rd_wdata_o,
    output logic              done_o,
    output logic              illegal_o
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Latched request fields; the requester may change its inputs freely
    // once the handshake has happened.
    logic [1:0]        op_q;
    logic              imm_q;
    logic [CSR_AW-1:0] addr_q;
    logic [REG_AW-1:0] rs1_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [4:0]        zimm_q;
    logic [REG_AW-1:0] rd_q;

    logic              accept;
    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] new_val;
    logic              src_zero;
    logic              do_wr;
    logic              read_only;
    logic              illegal;

    assign req_ready_o = (state_q == S_IDLE) && !rst;
    assign accept      = req_valid_i && req_ready_o;

    // The read address comes straight from the latched address so the
    // regfile's combinational read data is stable during READ.
    assign csr_raddr_o = addr_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE waits for a handshake, READ and WRITE last
    // exactly one cycle each.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request on the handshake edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= 2'b00;
            imm_q      <= 1'b0;
            addr_q     <= '0;
            rs1_q      <= '0;
            rs1_data_q <= '0;
            zimm_q     <= '0;
            rd_q       <= '0;
        end else if (accept) begin
            op_q       <= req_op_i;
            imm_q      <= req_imm_i;
            addr_q     <= req_csr_addr_i;
            rs1_q      <= req_rs1_i;
            rs1_data_q <= req_rs1_data_i;
            zimm_q     <= req_zimm_i;
            rd_q       <= req_rd_i;
        end
    end

    // Read-modify-write datapath, evaluated during READ against the live
    // CSR read data. A zero source on RS/RC suppresses the CSR write, which
    // is what lets a read-only CSR be read without trapping.
    always_comb begin
        src       = imm_q ? {{(DATA_W-5){1'b0}}, zimm_q} : rs1_data_q;
        src_zero  = imm_q ? (zimm_q == 5'd0) : (rs1_q == '0);
        do_wr     = (op_q == OP_RW) || !src_zero;
        read_only = (addr_q[CSR_AW-1 -: 2] == 2'b11);
        illegal   = (op_q == 2'b00) || (do_wr && read_only);
        new_val   = src;
        case (op_q)
            OP_RW:   new_val = src;
            OP_RS:   new_val = csr_rdata_i | src;
            OP_RC:   new_val = csr_rdata_i & ~src;
            default: new_val = src;
        endcase
    end

    // Output registers: loaded on the edge leaving READ so they are visible
    // for exactly the WRITE cycle, and returned to idle values on every other
    // edge. Reset while in READ therefore never produces a write pulse, and
    // reset during WRITE leaves that cycle's write intact.
    always_ff @(posedge clk) begin
        if (rst || state_q != S_READ) begin
            csr_waddr_o <= NOP_CSR_ADDR;
            csr_wdata_o <= '0;
            rd_waddr_o  <= '0;
            rd_wdata_o  <= '0;
            done_o      <= 1'b0;
            illegal_o   <= 1'b0;
        end else begin
            done_o    <= 1'b1;
            illegal_o <= illegal;
            if (!illegal && do_wr) begin
                csr_waddr_o <= addr_q;
                csr_wdata_o <= new_val;
            end else begin
                csr_waddr_o <= NOP_CSR_ADDR;
                csr_wdata_o <= '0;
            end
            if (!illegal) begin
                rd_waddr_o <= rd_q;
                rd_wdata_o <= csr_rdata_i;
            end else begin
                rd_waddr_o <= '0;
                rd_wdata_o <= '0;
            end
        end
    end

endmodule
